// File: rtl/id_ex_skid.sv
// id_ex_skid: ID->EX pipeline boundary with a valid/ready handshake.
// It holds up to two beats (a main entry that drives the outputs and a skid entry),
// so in_ready can come from a register and the stage still passes one beat per cycle.
// A flush kills every held beat for branch redirects. A zeroed NOP bubble is shown
// whenever no beat is valid. Two saturating counters record stall and bubble cycles.
module id_ex_skid #(
   parameter int DATA_W = 128,
   parameter int RD_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]   in_rdest,
   input  logic              in_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rdest,
   output logic              out_we,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // An entry is packed as {we, rdest, data}
   localparam int ENT_W = DATA_W + RD_W + 1;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [ENT_W-1:0] main_r;
   logic [ENT_W-1:0] main_nxt_s;
   logic [ENT_W-1:0] skid_r;
   logic [ENT_W-1:0] skid_nxt_s;
   logic [ENT_W-1:0] in_ent_s;
   logic             out_valid_r;
   logic             in_ready_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] bubble_cnt_r;
   logic             accept_s;
   logic             consume_s;

   // Counter increment that holds at the all-ones value instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   assign in_ent_s  = {in_we, in_rdest, in_data};
   assign accept_s  = in_valid && in_ready_r;
   assign consume_s = out_valid_r && out_ready;

   // The main entry is zero whenever it is invalid, so the outputs are a NOP without extra gating
   assign out_valid  = out_valid_r;
   assign in_ready   = in_ready_r;
   assign out_data   = main_r[DATA_W-1:0];
   assign out_rdest  = main_r[DATA_W+RD_W-1:DATA_W];
   assign out_we     = main_r[ENT_W-1];
   assign stall_cnt  = stall_cnt_r;
   assign bubble_cnt = bubble_cnt_r;

   // Next occupancy and entry contents from accept/consume; flush overrides everything
   always_comb begin
      state_nxt_s = state_r;
      main_nxt_s  = main_r;
      skid_nxt_s  = skid_r;
      if (flush) begin
         state_nxt_s = ST_EMPTY;
         main_nxt_s  = {ENT_W{1'b0}};
         skid_nxt_s  = {ENT_W{1'b0}};
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_nxt_s = ST_ONE;
                  main_nxt_s  = in_ent_s;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && !consume_s) begin
                  state_nxt_s = ST_FULL;
                  skid_nxt_s  = in_ent_s;
               end else if (accept_s && consume_s) begin
                  state_nxt_s = ST_ONE;
                  main_nxt_s  = in_ent_s;
               end else if (consume_s) begin
                  state_nxt_s = ST_EMPTY;
                  main_nxt_s  = {ENT_W{1'b0}};
               end else begin
                  state_nxt_s = ST_ONE;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the drain path exists
               if (consume_s) begin
                  state_nxt_s = ST_ONE;
                  main_nxt_s  = skid_r;
                  skid_nxt_s  = {ENT_W{1'b0}};
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            default: begin
               state_nxt_s = ST_EMPTY;
               main_nxt_s  = {ENT_W{1'b0}};
               skid_nxt_s  = {ENT_W{1'b0}};
            end
         endcase
      end
   end

   // Storage and registered handshake flags, derived from the next occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         main_r      <= {ENT_W{1'b0}};
         skid_r      <= {ENT_W{1'b0}};
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         main_r      <= main_nxt_s;
         skid_r      <= skid_nxt_s;
         out_valid_r <= (state_nxt_s != ST_EMPTY);
         in_ready_r  <= (state_nxt_s != ST_FULL);
      end
   end

   // Performance counters sampled on the pre-edge handshake; flush leaves them alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r  <= {CNT_W{1'b0}};
         bubble_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (out_valid_r && !out_ready) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end
         if (!out_valid_r && out_ready) begin
            bubble_cnt_r <= sat_inc(bubble_cnt_r);
         end
      end
   end

endmodule

// File: doc/id_ex_skid.md
Name: id_ex_skid

Overview:
- Parametrised ID→EX pipeline boundary replacing the fixed stall-vector register with a valid/ready handshake.
- Holds up to two beats (output register plus skid register), so the upstream ready is registered and full throughput is kept.
- Adds a synchronous flush for branch redirects.
- Emits zeroed NOP bubbles whenever no valid beat is present.
- Keeps saturating stall/bubble counters for performance inspection.

Parameters:
- DATA_W, 128, width of packed payload (exec code, rs1, rs2, imm, addr, mux select).
- RD_W, 5, destination register address width.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held and incoming beats.
- in_valid  in  1  decode presents a beat.
- in_ready  out  1  stage can accept a beat; registered.
- in_data  in  DATA_W  payload from decode.
- in_rdest  in  RD_W  destination register.
- in_we  in  1  register write enable.
- out_valid  out  1  beat presented to execute.
- out_ready  in  1  execute consumes this cycle.
- out_data  out  DATA_W  payload to execute.
- out_rdest  out  RD_W  destination register to execute.
- out_we  out  1  write enable to execute.
- stall_cnt  out  CNT_W  cycles with out_valid=1 && out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 && out_ready=1.

Behaviour:
- Storage and handshake:
  - Two entries: main (drives out_*) and skid.
  - accept = in_valid && in_ready.
  - consume = out_valid && out_ready.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- Transitions:
  - EMPTY: accept → ONE (beat into main).
  - ONE, accept && !consume → FULL (beat into skid).
  - ONE, accept && consume → ONE (beat into main).
  - ONE, !accept && consume → EMPTY.
  - FULL, consume → ONE (skid moves into main). in_ready is 0, so no accept is possible.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. It is a register output, never combinational from out_ready.
- Timing and ordering:
  - Latency from accept to out_valid is 1 cycle.
  - Sustained throughput is 1 beat/cycle when out_ready is held high.
  - Beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush.
- Bubble rule: whenever out_valid=0, out_data, out_rdest and out_we are all 0, so execute sees a NOP with write disabled.
- flush:
  - Highest priority after rst.
  - Next edge: state → EMPTY, both entries zeroed, in_ready → 1.
  - A beat offered in the flush cycle is discarded even if in_ready=1.
  - A consume in the flush cycle still counts as delivered to execute.
- Counters:
  - Each counter increments by 1 on its condition and saturates at 2^CNT_W−1.
  - Counters are evaluated on the pre-edge out_valid/out_ready.
  - flush does not clear them; only rst does.
- Reset (rst=1, asynchronous):
  - out_valid=0, out_data=0, out_rdest=0, out_we=0.
  - in_ready=1, stall_cnt=0, bubble_cnt=0, state EMPTY.
  - Reset asserted mid-transfer drops all held beats immediately, without waiting for a clock edge.
  - First accept is possible on the first edge after rst deasserts.
- Simultaneous events:
  - flush with rst: rst wins.
  - flush with FULL && consume: the main beat is delivered, the skid beat is discarded.

Test Plan:
- Reset then stream: rst pulse; in_valid=1 for 4 cycles with in_data=1..4, out_ready=1 → out_data 1,2,3,4 on cycles 1–4; in_ready stays 1; bubble_cnt=1, counting only the first cycle.
- Backpressure: send A=0xA, B=0xB; out_ready=0 for 3 cycles → out_data holds 0xA; in_ready falls to 0 after B is accepted; stall_cnt=3; out_ready=1 → A then B delivered, in_ready=1 again.
- Flush in FULL: state FULL with 0xA/0xB, flush=1 with out_ready=0 → next cycle out_valid=0, out_data=0, out_we=0, in_ready=1; neither beat ever appears.
- Flush with offered beat: EMPTY, in_valid=1, in_data=0x55, flush=1 → out_valid stays 0 on the following cycle.
- Async reset mid-stream: rst asserted between edges while FULL → outputs zero and in_ready=1 immediately, before the next edge; counters read 0.
- Counter saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15, no wrap to 0.
